// File: rtl/inv_substitute_serial_if.sv
// Handshake bundle for the serial InvSubBytes engine: an input valid/ready
// channel carrying one 128-bit state and an output valid/ready channel
// carrying the substituted state, plus the busy status flag.
interface inv_substitute_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;

  // Producer/consumer side (drives requests, consumes results)
  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  // Engine side
  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/inv_substitute_serial.sv
// Iterative AES InvSubBytes engine. A 128-bit state is captured into a
// working register and BYTES_PER_CYCLE bytes per clock are replaced by their
// inverse S-box values, most significant group first. The finished state is
// held on the output channel until the consumer takes it.
module inv_substitute_serial #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_substitute_serial_if.slave bus
);

  localparam int N     = 16 / BYTES_PER_CYCLE;
  localparam int GRP_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(N - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Inverse S-box table, entry 0 in the leftmost (most significant) slot.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [127:0]       work;
  logic [127:0]       work_next;
  logic [GRP_W-1:0]   grp;

  // Substitute the bytes of the current group; all other bytes pass through
  always_comb begin
    int base;
    work_next = work;
    base      = int'(grp) * BYTES_PER_CYCLE;
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      work_next[8*(15-(base+g)) +: 8] = inv_sbox(work[8*(15-(base+g)) +: 8]);
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = SUB;
      SUB:     if (grp == GRP_LAST) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, group counter and working register; reset wins over any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      grp   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work <= bus.data_in;
            grp  <= '0;
          end
        end
        SUB: begin
          work <= work_next;
          grp  <= (grp == GRP_LAST) ? '0 : grp + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.data_out  = work;

endmodule

// File: tb/tb_inv_substitute_serial.sv
// Bench for the serial InvSubBytes engine. Five instances (1, 2, 4, 8 and 16
// lookups per cycle) share one stimulus source. The 4-wide instance is
// tracked by a scoreboard; the others are checked in lock-step phases that
// start from reset. The reference table is derived from GF(2^8) inversion
// and the affine map rather than from a stored table.
module tb_inv_substitute_serial;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] data_in;
  logic         out_ready;

  always #5 clk = ~clk;

  inv_substitute_serial_if bus1 ();
  inv_substitute_serial_if bus2 ();
  inv_substitute_serial_if bus4 ();
  inv_substitute_serial_if bus8 ();
  inv_substitute_serial_if bus16 ();

  assign bus1.in_valid  = in_valid;  assign bus1.data_in  = data_in;  assign bus1.out_ready  = out_ready;
  assign bus2.in_valid  = in_valid;  assign bus2.data_in  = data_in;  assign bus2.out_ready  = out_ready;
  assign bus4.in_valid  = in_valid;  assign bus4.data_in  = data_in;  assign bus4.out_ready  = out_ready;
  assign bus8.in_valid  = in_valid;  assign bus8.data_in  = data_in;  assign bus8.out_ready  = out_ready;
  assign bus16.in_valid = in_valid;  assign bus16.data_in = data_in;  assign bus16.out_ready = out_ready;

  inv_substitute_serial #(.BYTES_PER_CYCLE(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  inv_substitute_serial #(.BYTES_PER_CYCLE(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));
  inv_substitute_serial #(.BYTES_PER_CYCLE(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  inv_substitute_serial #(.BYTES_PER_CYCLE(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
  inv_substitute_serial #(.BYTES_PER_CYCLE(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  // Index j of these vectors corresponds to WID[j] lookups per cycle
  localparam int WID [5] = '{1, 2, 4, 8, 16};
  localparam int MAIN = 2;

  logic [4:0]   ov, ir, bz;
  logic [127:0] dout [5];
  assign ov = {bus16.out_valid, bus8.out_valid, bus4.out_valid, bus2.out_valid, bus1.out_valid};
  assign ir = {bus16.in_ready,  bus8.in_ready,  bus4.in_ready,  bus2.in_ready,  bus1.in_ready};
  assign bz = {bus16.busy,      bus8.busy,      bus4.busy,      bus2.busy,      bus1.busy};
  assign dout[0] = bus1.data_out;
  assign dout[1] = bus2.data_out;
  assign dout[2] = bus4.data_out;
  assign dout[3] = bus8.data_out;
  assign dout[4] = bus16.data_out;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*(15-j) +: 8] = inv_tab[d[8*(15-j) +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- scoreboard on the 4-wide instance ----------------
  logic [127:0] exp_q [$];
  int n_pop = 0;

  // Record the expected result of every accepted block; reset discards them
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else if (in_valid && ir[MAIN]) exp_q.push_back(model(data_in));
  end

  // Compare every handed-off result against the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && ov[MAIN] && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_output: got %h, expected no output", dout[MAIN]);
      end else begin
        check("sb_data", dout[MAIN], exp_q.pop_front());
        n_pop++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one block to every instance at once and check latency, data and
  // in_ready recovery for each width. All instances must be idle on entry.
  task automatic run_lockstep(input logic [127:0] d, input logic [127:0] exp, input string tag);
    bit seen [5];
    for (int j = 0; j < 5; j++) seen[j] = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b1; data_in = d; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_accept_ready"}, 128'(ir), 128'(5'h1f));
    @(posedge clk);
    #1 in_valid = 1'b0; data_in = rand128();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int j = 0; j < 5; j++) begin
        int lat = 16 / WID[j];
        if (!seen[j] && ov[j]) begin
          seen[j] = 1'b1;
          check($sformatf("%s_latency_b%0d", tag, WID[j]), 128'(k), 128'(lat));
          check($sformatf("%s_data_b%0d", tag, WID[j]), dout[j], exp);
        end
        if (k == lat + 1)
          check($sformatf("%s_in_ready_back_b%0d", tag, WID[j]), 128'(ir[j]), 128'(1));
      end
    end
    for (int j = 0; j < 5; j++)
      if (!seen[j]) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout_b%0d: got no out_valid, expected one", tag, WID[j]);
      end
  endtask

  // Wait (bounded) for the 4-wide instance to present a result
  task automatic wait_main_out(input string tag);
    int w = 0;
    @(negedge clk);
    while (!ov[MAIN] && w < 30) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_out_valid_seen"}, 128'(ov[MAIN]), 128'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] d;
    int pop0;
    bit done;

    rst = 1'b1; in_valid = 1'b0; data_in = '0; out_ready = 1'b0;
    build_tables();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", 128'(ir), 128'(0));
    check("rst_out_valid", 128'(ov), 128'(0));
    check("rst_busy", 128'(bz), 128'(0));
    check("rst_data_out", dout[MAIN], 128'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 128'(ir), 128'(5'h1f));

    // Known vector and boundary bytes across all widths
    run_lockstep(128'h638293c31bfc33f5c4eeacea4bc12816,
                 128'h00112233445566778899aabbccddeeff, "known");
    do_reset();
    run_lockstep(128'h637c00ff16ed63636363636363636363,
                 128'h0001527dff5300000000000000000000, "boundary");
    for (int r = 0; r < 2; r++) begin
      do_reset();
      d = rand128();
      run_lockstep(d, model(d), $sformatf("rand%0d", r));
    end

    // Backpressure: result held with in_valid asserted and data_in toggling
    do_reset();
    d = rand128();
    @(posedge clk);
    #1 in_valid = 1'b1; data_in = d; out_ready = 1'b0;
    @(posedge clk);
    #1 data_in = ~data_in;
    wait_main_out("bp");
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid_held", 128'(ov[MAIN]), 128'(1));
      check("bp_data_held", dout[MAIN], model(d));
      check("bp_in_ready_low", 128'(ir[MAIN]), 128'(0));
      @(posedge clk);
      #1 data_in = ~data_in;
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("bp_after_handoff_out_valid", 128'(ov[MAIN]), 128'(0));
    check("bp_after_handoff_busy", 128'(bz[MAIN]), 128'(0));
    check("bp_after_handoff_in_ready", 128'(ir[MAIN]), 128'(1));

    // Input ignored while substituting
    do_reset();
    d = rand128();
    @(posedge clk);
    #1 in_valid = 1'b1; data_in = d; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 in_valid = (i != 1); data_in = rand128();
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_main_out("ignore");
    check("ignore_data", dout[MAIN], model(d));
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset in the middle of a block
    do_reset();
    @(posedge clk);
    #1 in_valid = 1'b1; data_in = rand128(); out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 128'(ov[MAIN]), 128'(0));
    check("midrst_busy", 128'(bz[MAIN]), 128'(0));
    check("midrst_data_out", dout[MAIN], 128'h0);
    check("midrst_in_ready", 128'(ir[MAIN]), 128'(1));
    run_lockstep({16{8'h63}}, 128'h0, "after_rst");

    // Back-to-back random blocks with random gaps and backpressure
    do_reset();
    pop0 = n_pop;
    done = 1'b0;
    fork
      begin
        for (int b = 0; b < 8; b++) begin
          int w = 0;
          int gap = int'($urandom_range(0, 3));
          #0 in_valid = 1'b0;
          repeat (gap) begin
            @(posedge clk);
            #1;
          end
          in_valid = 1'b1;
          data_in = rand128();
          @(negedge clk);
          while (!ir[MAIN] && w < 60) begin
            @(negedge clk);
            w++;
          end
          if (!ir[MAIN]) begin
            tests++;
            fails++;
            $display("FAIL b2b_accept_timeout: got in_ready 0, expected 1");
          end
          @(posedge clk);
          #1 in_valid = 1'b0;
        end
        for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(negedge clk);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    check("b2b_queue_drained", 128'(exp_q.size()), 128'(0));
    check("b2b_handoff_count", 128'(n_pop - pop0), 128'(8));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute bound on the run
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_substitute_serial.md
# inv_substitute_serial

Iterative AES InvSubBytes engine: accepts one 128-bit state over a valid/ready handshake and replaces every byte with its FIPS-197 inverse S-box value. It processes BYTES_PER_CYCLE bytes per clock, and presents the result on a second valid/ready handshake. It sits in the decryption datapath as the inverse of the 16-way parallel forward substitution stage. It trades latency for area: BYTES_PER_CYCLE inverse S-box lookups instead of 16.

## Interface
- BYTES_PER_CYCLE, 4, inverse S-box lookups per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  data_in holds a state to transform
- in_ready  output  1  block can accept a state
- data_in  input  128  input state; byte 0 = bits [127:120], byte 15 = bits [7:0]
- out_valid  output  1  data_out holds the finished inverse-substituted state
- out_ready  input  1  downstream consumes data_out
- data_out  output  128  working register; same byte order as data_in
- busy  output  1  high in SUB or DONE

## Operation
- N = 16 / BYTES_PER_CYCLE substitution cycles per block.
- The inverse S-box is an internal combinational 256×8 ROM (FIPS-197 Fig. 14), replicated BYTES_PER_CYCLE times.
- Registers:
  - work (128 bits)
  - grp counter (ceil(log2 N) bits, min 1)
  - state ∈ {IDLE, SUB, DONE}
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: work ← data_in, grp ← 0, go to SUB.
- SUB:
  - Bytes grp·B … grp·B+B−1 of work (B = BYTES_PER_CYCLE) are replaced by their InvSBox values. Groups run MSB-first.
  - grp increments by 1.
  - When grp == N−1, go to DONE; grp wraps to 0.
  - in_ready = 0. in_valid is ignored, and data_in may change freely.
- DONE:
  - out_valid = 1; work is frozen.
  - On out_ready, go to IDLE.
  - A new block is never accepted in the same cycle as output handoff.
- For BYTES_PER_CYCLE = 16, SUB lasts exactly one cycle.
- data_out = work at all times. Contents are contractually defined only while out_valid = 1.
- Outputs after any rst cycle: state IDLE, work = 0, grp = 0, out_valid = 0, busy = 0, data_out = 0.
- in_ready is 0 while rst = 1 and 1 on the first cycle after rst deasserts.
- rst in any state aborts the block immediately:
  - no out_valid pulse;
  - the partially transformed data is discarded;
  - rst has priority over every handshake in the same cycle.

## Timing
- Acceptance edge E0 (in_valid && in_ready sampled high).
- Group k is written on edge E(k+1).
- out_valid rises after edge EN, so latency is N cycles from acceptance to out_valid (default: 4).
- out_valid and data_out hold stable until the edge where out_ready is sampled high. Both must hold indefinitely under backpressure.
- in_ready rises the cycle after output handoff.
- Maximum throughput is one block per N+2 cycles.
- out_ready is sampled only in DONE; asserting it early has no effect.
- No combinational path from in_valid or out_ready to any output. in_ready, out_valid and busy decode directly from state (and rst, for in_ready).

## Test plan
- Known vector, B=4:
  - Stimulus: data_in = 638293c31bfc33f5c4eeacea4bc12816, out_ready held 1.
  - Required: out_valid exactly 4 cycles after acceptance, data_out = 00112233445566778899aabbccddeeff, in_ready back 1 two cycles after acceptance + 4.
- Boundary bytes:
  - Stimulus: data_in bytes = 63,7C,00,FF,16,ED repeated/padded with 63.
  - Required: corresponding outputs 00,01,52,7D,FF,53.
  - Run for BYTES_PER_CYCLE = 1 (latency 16), 2, 8 and 16 (latency 1); results must match.
- Backpressure:
  - Stimulus: out_ready = 0 for 20 cycles after out_valid, with in_valid held 1 and data_in toggled each cycle.
  - Required: data_out and out_valid unchanged, in_ready = 0 throughout; one handoff when out_ready rises.
- Input ignored mid-operation:
  - Stimulus: change data_in and pulse in_valid during SUB.
  - Required: result equals the transform of the originally accepted value only.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle at E2 of a block.
  - Required: next cycle out_valid = 0, busy = 0, data_out = 0, in_ready = 1.
  - A following block with data_in all 0x63 yields all 0x00 with normal latency.
- Back-to-back:
  - Stimulus: 8 random blocks with random in_valid/out_ready gaps.
  - Required: every output matches a software InvSubBytes model, in order, with no drops or duplicates.
